// File: rtl/flasher_pkg.sv
// Shared types and constants for the bound-flasher controller.
package flasher_pkg;

    localparam int unsigned LED_W        = 16;
    localparam int unsigned KICK_TIMEOUT = 4;

    typedef enum logic [1:0] {
        StIdle,
        StKick,
        StRun
    } state_t;

endpackage

// File: rtl/flasher_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-count debouncer and press detect.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic deb,
    output logic press
);

    localparam int unsigned CntW = $clog2(DEB_CYCLES + 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] mis_cnt_q, mis_cnt_d;
    logic            deb_q, deb_d;
    logic            deb_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            mis_cnt_q  <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
        end else begin
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            mis_cnt_q  <= mis_cnt_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
        end
    end

    // The last mismatching cycle flips the level and restarts the count.
    always_comb begin
        mis_cnt_d = '0;
        deb_d     = deb_q;
        if (sync2_q != deb_q) begin
            if (mis_cnt_q == CntW'(DEB_CYCLES - 1)) begin
                deb_d = ~deb_q;
            end else begin
                mis_cnt_d = mis_cnt_q + 1'b1;
            end
        end
    end

    assign deb   = deb_q;
    assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/flasher_ctrl.sv
// Sequencer for the 16-LED bound flasher: step prescaler, start/run/auto-repeat FSM
// and run bookkeeping. All outputs are registered.
module flasher_ctrl
    import flasher_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned RUN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_in,
    input  logic [DIV_W-1:0] div_val,
    input  logic             auto_en,
    input  logic [RUN_W-1:0] auto_runs,
    input  logic [LED_W-1:0] leds,
    output logic             step_en,
    output logic             flick,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [RUN_W-1:0] run_cnt
);

    localparam int unsigned KickW = $clog2(KICK_TIMEOUT + 1);

    logic deb, press;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_in(btn_in),
        .deb   (deb),
        .press (press)
    );

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               step_en_q, step_en_d;
    logic [RUN_W-1:0]   runs_left_q, runs_left_d;
    logic [KickW-1:0]   kick_steps_q, kick_steps_d;
    logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
    logic               flick_q, flick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [RUN_W-1:0]   runs_load;

    assign runs_load = (auto_en && (auto_runs != '0)) ? auto_runs : RUN_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            step_en_q    <= 1'b0;
            runs_left_q  <= '0;
            kick_steps_q <= '0;
            run_cnt_q    <= '0;
            flick_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_en_q    <= step_en_d;
            runs_left_q  <= runs_left_d;
            kick_steps_q <= kick_steps_d;
            run_cnt_q    <= run_cnt_d;
            flick_q      <= flick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // '>=' rather than '==' so a divider lowered mid-count fires on the next cycle.
    always_comb begin
        step_en_d = 1'b0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q >= div_val) begin
            step_en_d = 1'b1;
            cnt_d     = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        runs_left_d  = runs_left_q;
        kick_steps_d = kick_steps_q;
        run_cnt_d    = run_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (press && (leds == '0)) begin
                    state_d      = StKick;
                    runs_left_d  = runs_load;
                    kick_steps_d = '0;
                end
            end
            StKick: begin
                if (leds != '0) begin
                    state_d = StRun;
                end else if (step_en_q) begin
                    if (kick_steps_q == KickW'(KICK_TIMEOUT - 1)) begin
                        state_d = StIdle;
                    end else begin
                        kick_steps_d = kick_steps_q + 1'b1;
                    end
                end
            end
            StRun: begin
                // Run end takes priority; a press here is simply not looked at.
                if (leds == '0) begin
                    if (run_cnt_q != '1) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                    runs_left_d  = runs_left_q - 1'b1;
                    kick_steps_d = '0;
                    state_d      = (runs_left_q > RUN_W'(1)) ? StKick : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        flick_d = 1'b0;
        unique case (state_d)
            StKick:  flick_d = 1'b1;
            StRun:   flick_d = deb;
            default: flick_d = 1'b0;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_q == StRun) && (state_d == StIdle);
        err_d  = (state_q == StKick) && (state_d == StIdle);
    end

    assign step_en = step_en_q;
    assign flick   = flick_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_flasher_ctrl.sv
// Randomised scoreboard bench for flasher_ctrl with a behavioural reference model.
module tb_flasher_ctrl;
    import flasher_pkg::*;

    localparam int unsigned DEB   = 4;
    localparam int unsigned DIV_W = 16;
    localparam int unsigned RUN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             btn_in = 1'b0;
    logic [DIV_W-1:0] div_val = 16'd3;
    logic             auto_en = 1'b0;
    logic [RUN_W-1:0] auto_runs = '0;
    logic [LED_W-1:0] leds = '0;
    logic             step_en, flick, busy, done, err;
    logic [RUN_W-1:0] run_cnt;

    always #5 clk = ~clk;

    flasher_ctrl #(
        .DEB_CYCLES(DEB),
        .DIV_W     (DIV_W),
        .RUN_W     (RUN_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_in   (btn_in),
        .div_val  (div_val),
        .auto_en  (auto_en),
        .auto_runs(auto_runs),
        .leds     (leds),
        .step_en  (step_en),
        .flick    (flick),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .run_cnt  (run_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
    endtask

    // Reference model: advances one clock per posedge, from inputs only.
    logic [12:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit m_b1, m_b2, m_deb, m_deb_prev, m_step, m_flick, m_busy, m_done, m_err;
    bit m_synced, m_press, m_old_deb, m_new_deb, m_step_pre;
    int m_mis, m_since, m_phase, m_runs, m_kicks, m_runcnt;

    initial forever begin
        @(posedge clk);
        if (mon_en) begin
            if (rst) begin
                m_b1 = 0; m_b2 = 0; m_deb = 0; m_deb_prev = 0; m_step = 0;
                m_flick = 0; m_busy = 0; m_done = 0; m_err = 0;
                m_mis = 0; m_since = 0; m_phase = 0; m_runs = 0; m_kicks = 0; m_runcnt = 0;
            end else begin
                m_synced = m_b2;
                m_b2 = m_b1;
                m_b1 = btn_in;
                m_press = m_deb && !m_deb_prev;
                m_old_deb = m_deb;
                m_new_deb = m_deb;
                if (m_synced != m_deb) begin
                    m_mis++;
                    if (m_mis >= int'(DEB)) begin
                        m_new_deb = !m_deb;
                        m_mis = 0;
                    end
                end else begin
                    m_mis = 0;
                end
                m_step_pre = m_step;
                m_step = (m_since >= int'(div_val));
                m_since = m_step ? 0 : m_since + 1;
                m_done = 0;
                m_err = 0;
                case (m_phase)
                    0: if (m_press && leds == 0) begin
                        m_phase = 1;
                        m_runs = (auto_en && auto_runs != 0) ? int'(auto_runs) : 1;
                        m_kicks = 0;
                    end
                    1: if (leds != 0) m_phase = 2;
                       else if (m_step_pre) begin
                           m_kicks++;
                           if (m_kicks >= int'(KICK_TIMEOUT)) begin
                               m_phase = 0;
                               m_err = 1;
                           end
                       end
                    default: if (leds == 0) begin
                        if (m_runcnt < 255) m_runcnt++;
                        m_runs--;
                        if (m_runs > 0) begin
                            m_phase = 1;
                            m_kicks = 0;
                        end else begin
                            m_phase = 0;
                            m_done = 1;
                        end
                    end
                endcase
                m_flick = (m_phase == 1) ? 1'b1 : (m_phase == 2) ? m_old_deb : 1'b0;
                m_busy = (m_phase != 0);
                m_deb_prev = m_deb;
                m_deb = m_new_deb;
            end
            exp_q.push_back({m_step, m_flick, m_busy, m_done, m_err, 8'(m_runcnt)});
        end
    end

    // Monitor: outputs are sampled mid-cycle; while reset is held they must read zero.
    logic [12:0] mon_e;
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_underflow: no expected entry at t=%0t", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (rst) mon_e = '0;
                chk("sb_outputs", 32'({step_en, flick, busy, done, err, run_cnt}), 32'(mon_e));
            end
        end
    end

    // Flasher stand-in: 0 = behavioural runs, 1 = stuck dark, 2 = forced lit.
    int fl_mode = 0;
    int fl_rem  = 0;
    initial forever begin
        @(posedge clk);
        #1;
        case (fl_mode)
            1: leds = '0;
            2: begin
                leds = 16'h0180;
                fl_rem = 0;
            end
            default: begin
                if (leds != '0) begin
                    if (step_en) begin
                        if (fl_rem <= 1) leds = '0;
                        else begin
                            fl_rem--;
                            leds = {leds[14:0], leds[15]};
                        end
                    end
                end else if (flick && step_en) begin
                    leds = 16'h0001 << $urandom_range(0, 15);
                    fl_rem = int'($urandom_range(2, 6));
                end
            end
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic bit cond(input int which);
        case (which)
            0: return done;
            1: return err;
            3: return !busy;
            4: return busy && (leds != '0);
            5: return leds == '0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int bound, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            step(1);
            hit = cond(which);
        end
        chk({"wait_", nm}, 32'(hit), 32'd1);
    endtask

    task automatic press_btn();
        btn_in = 1'b1;
        step(DEB + 3);
        btn_in = 1'b0;
    endtask

    initial begin
        int n;
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        mon_en = 1'b1;
        step(3);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;

        // Prescaler: div 3 fires at cycles 4 and 8, then 3->0 mid-count.
        step(3);
        chk("step_not_yet", 32'(step_en), 0);
        step(1);
        chk("step_cycle4", 32'(step_en), 1);
        step(4);
        chk("step_cycle8", 32'(step_en), 1);
        step(2);
        div_val = 16'd0;
        step(1);
        chk("step_after_lower", 32'(step_en), 1);
        step(1);
        chk("step_every_cycle", 32'(step_en), 1);
        div_val = 16'd1;

        for (int g = 1; g <= 3; g++) begin
            btn_in = 1'b1;
            step(g);
            btn_in = 1'b0;
            step(8);
            chk("glitch_no_flick", 32'({flick, busy}), 0);
        end

        // Clean press: flick registered DEB+2 edges after the first high sample.
        btn_in = 1'b1;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!flick && n < 20);
        chk("start_latency", 32'(n - 1), 32'(DEB + 2));
        step(3);
        btn_in = 1'b0;
        wait_for(0, 500, "single_done");
        step(1);
        chk("single_run_cnt", 32'(run_cnt), 1);
        chk("single_idle", 32'({flick, busy, done}), 0);

        // Auto-repeat 3; a mid-run change of auto_runs must not matter.
        step(10);
        auto_en = 1'b1;
        auto_runs = 8'd3;
        press_btn();
        auto_runs = 8'd7;
        wait_for(0, 3000, "auto3_done");
        chk("auto3_run_cnt", 32'(run_cnt), 4);
        step(10);
        auto_runs = 8'd0;
        press_btn();
        wait_for(0, 1000, "auto0_done");
        chk("auto0_run_cnt", 32'(run_cnt), 5);

        // Kick timeout with a dark flasher.
        step(10);
        auto_en = 1'b0;
        fl_mode = 1;
        press_btn();
        wait_for(1, 200, "kick_err");
        chk("timeout_run_cnt", 32'(run_cnt), 5);
        step(1);
        chk("timeout_idle", 32'({busy, done, err}), 0);
        fl_mode = 0;

        // Reset during RUN, then a press with lit LEDs.
        step(10);
        div_val = 16'd2;
        press_btn();
        wait_for(4, 200, "enter_run");
        rst = 1'b1;
        #1;
        chk("rst_in_run", 32'({flick, busy, run_cnt}), 0);
        step(2);
        rst = 1'b0;
        fl_mode = 2;
        step(3);
        press_btn();
        step(10);
        chk("press_lit_ignored", 32'(busy), 0);
        fl_mode = 0;
        wait_for(5, 100, "leds_dark");
        step(10);

        // Held button is forwarded on flick during RUN.
        btn_in = 1'b1;
        step(DEB + 3);
        wait_for(4, 200, "fwd_run");
        step(1);
        chk("flick_forward", 32'(flick), 1);
        btn_in = 1'b0;
        wait_for(0, 500, "fwd_done");
        step(10);

        for (int it = 0; it < 8; it++) begin
            div_val = 16'($urandom_range(0, 3));
            auto_en = 1'($urandom_range(0, 1));
            auto_runs = 8'($urandom_range(0, 3));
            fl_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            btn_in = 1'b1;
            step(int'($urandom_range(1, 3)));
            btn_in = 1'b0;
            step(8);
            press_btn();
            wait_for(3, 3000, "rand_idle");
            fl_mode = 0;
            step(12);
        end

        step(3);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
